afifo_stream_reader: RTL
========================

// Module: afifo_stream_reader
// PURPOSE
//  Consumer for the async FIFO read port, in the FIFO read clock domain.
//  Pops words whenever buffer space exists and presents them on a registered valid/ready stream through a 2-entry skid buffer.
//  Marks every FRAME_LEN-th delivered word with out_last and counts delivered words.
// PARAMETERS
//  WIDTH        32  data width; must equal the FIFO WIDTH
//  FRAME_LEN     8  words per frame, >=1; out_last is asserted on word FRAME_LEN-1 of each frame
//  COUNT_WIDTH  16  width of word_count
// PORTS
//  clk           in   1        read-domain clock, the same clock as the FIFO read_clk
//  reset         in   1        asynchronous, active-high; outputs take reset values immediately
//  enable        in   1        1 = allowed to pop the FIFO; 0 = stop popping, buffered words still drain
//  fifo_empty    in   1        FIFO empty flag
//  fifo_read_data in  WIDTH    FIFO head word; valid in the same cycle whenever !fifo_empty
//  fifo_read_en  out  1        pop request to the FIFO
//  out_valid     out  1        out_data/out_last valid
//  out_ready     in   1        downstream accepts a word
//  out_data      out  WIDTH    stream data
//  out_last      out  1        last word of a frame
//  word_count    out  COUNT_WIDTH  words delivered since reset, wraps modulo 2^COUNT_WIDTH
// BEHAVIOUR
//  Event definitions:
//  - push = fifo_read_en.
//  - fifo_read_en = enable && !fifo_empty && state!=TWO. It never depends on out_ready.
//  - pop = out_valid && out_ready.
//  Registers:
//  - head register holds the word being presented.
//  - skid register holds the second buffered word.
//  - state is one of EMPTY, ONE, TWO, encoding occupancy 0, 1 or 2.
//  State transitions and data movement:
//  - EMPTY, push: head<=fifo_read_data; go to ONE.
//  - ONE, push and !pop: skid<=fifo_read_data; go to TWO.
//  - ONE, push and pop: head<=fifo_read_data; stay in ONE. This sustains 1 word/clk.
//  - ONE, pop and !push: go to EMPTY.
//  - ONE, no push and no pop: hold.
//  - TWO, pop: head<=skid; go to ONE. No push can occur in TWO.
//  - TWO, no pop: hold.
//  Output timing:
//  - out_valid = (state!=EMPTY), driven directly from a register.
//  - out_data = head register.
//  - Latency: a word popped at edge N is on out_data with out_valid=1 after edge N.
//  Stream rules and ordering:
//  - Words leave in FIFO order; none is dropped or duplicated.
//  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
//  Frame logic:
//  - frame_cnt ranges 0..FRAME_LEN-1 and advances on pop.
//  - frame_cnt wraps to 0 after the pop of word FRAME_LEN-1.
//  - out_last = out_valid && frame_cnt==FRAME_LEN-1.
//  - FRAME_LEN=1: out_last = out_valid.
//  word_count increments by 1 on every pop and wraps from all-ones to 0.
//  Reset values:
//  - state=EMPTY, frame_cnt=0, word_count=0.
//  - head=0, skid=0.
//  - out_valid=0, out_last=0, fifo_read_en=0.
//  Mid-operation reset: buffered words are discarded and the frame restarts at word 0.
//  The FIFO reset is independent; the system resets both together.
//  enable falling in TWO or ONE: no further pops; remaining words drain normally.
//  fifo_empty=1: fifo_read_en=0 regardless of other inputs, so no pop of an empty FIFO.
// TESTING
//  1 Reset, then feed FIFO words 1..8 with out_ready=1 -> fifo_read_en high 8 cycles.
//    out_data 1..8 on consecutive clocks; out_last only with data 8; word_count=8.
//  2 FIFO holds 10,11,12 with out_ready=0 -> exactly 2 pops; state=TWO; out_data=10 held.
//    fifo_read_en=0 while in TWO. Then out_ready=1 -> 10,11,12 delivered in order.
//  3 Toggle out_ready every cycle while streaming 16 words -> all 16 delivered in order.
//    out_last on words 8 and 16; data stable during stalls.
//  4 Hold enable=0 with a non-empty FIFO -> fifo_read_en=0, out_valid=0.
//    Raise enable -> first word on out_data one clock later.
//  5 Assert reset while state=TWO and frame_cnt=5 -> out_valid=0, word_count=0 immediately.
//    Subsequent frame marks out_last on its 8th word.
//  6 COUNT_WIDTH=4: deliver 17 words -> word_count=1 (wrapped).
//    FRAME_LEN=1 -> out_last=1 on every word.

Source files
------------

// File: rtl/afifo_stream_reader.sv
// rtl/afifo_stream_reader.sv - async FIFO read-side consumer feeding a 2-entry skid-buffered stream
module afifo_stream_reader #(
  parameter int WIDTH       = 32,
  parameter int FRAME_LEN   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_read_data,
  output logic                   fifo_read_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [WIDTH-1:0]       head_q, head_d;
  logic [WIDTH-1:0]       skid_q, skid_d;
  logic                   valid_q;
  logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
  logic                   push, pop;

  // Popping never looks at out_ready: the skid entry absorbs the word in flight.
  assign push = !reset && enable && !fifo_empty && (state_q != ST_TWO);
  assign pop  = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = fifo_read_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = fifo_read_data;
        end else if (push) begin
          skid_d  = fifo_read_data;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    word_count_d = word_count_q;
    if (pop) begin
      frame_cnt_d  = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + FC_W'(1);
      word_count_d = word_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      head_q       <= '0;
      skid_q       <= '0;
      valid_q      <= 1'b0;
      frame_cnt_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
      valid_q      <= (state_d != ST_EMPTY);
      frame_cnt_q  <= frame_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  assign fifo_read_en = push;
  assign out_valid    = valid_q;
  assign out_data     = head_q;
  assign out_last     = valid_q && (frame_cnt_q == FC_LAST);
  assign word_count   = word_count_q;

endmodule
